inst_cache: RTL and testbench

INST_CACHE -- requirements
Module: inst_cache

---
 rtl/inst_cache.sv | 77 +++++++
 tb/tb_inst_cache.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_cache.sv
// inst_cache: direct-mapped instruction cache, combinational hit path, 4-word line fill from memory
module inst_cache #(
  parameter int INDEX_BITS = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] pc_in,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  input  logic        flush,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
);
  localparam int LINE_WORDS = 4;
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 28 - INDEX_BITS;
  typedef enum logic {IDLE, FILL} state_t;
  state_t state, state_n;
  logic [1:0] cnt;
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags [LINES];
  logic [31:0] data [LINES][LINE_WORDS];
  logic [31:0] fill_buf [LINE_WORDS];
  logic [INDEX_BITS-1:0] idx, f_idx;
  logic [TAG_W-1:0] tag, f_tag;
  logic [1:0] off;
  logic hit, start, take, done;
  // the line being filled is identified by the outstanding request address
  always_comb begin
    idx = pc_in[3+INDEX_BITS:4];
    tag = pc_in[31:4+INDEX_BITS];
    off = pc_in[3:2];
    f_idx = mem_req_addr[3+INDEX_BITS:4];
    f_tag = mem_req_addr[31:4+INDEX_BITS];
    hit = state == IDLE && valid[idx] && tags[idx] == tag;
    inst_valid = hit && !flush;
    inst_out = data[idx][off];
    start = state == IDLE && rdy && !flush && !hit;
    take = state == FILL && rdy && mem_resp_valid;
    done = take && cnt == 2'd3;
    state_n = start ? FILL : done ? IDLE : state;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      valid <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr <= '0;
    end else if (rdy) begin
      state <= state_n;
      if (flush) valid <= '0;
      if (done) valid[f_idx] <= 1'b1;
      if (start) begin
        cnt <= '0;
        mem_req_valid <= 1'b1;
        mem_req_addr <= pc_in & ~32'hF;
      end else if (take) begin
        cnt <= cnt + 2'd1;
        mem_req_valid <= !done;
        mem_req_addr <= done ? mem_req_addr : mem_req_addr + 32'd4;
      end
    end
  // last word goes straight from the response into the array
  always_ff @(posedge clk)
    if (!rst && take) begin
      fill_buf[cnt] <= mem_resp_data;
      if (done) begin
        tags[f_idx] <= f_tag;
        for (int i = 0; i < LINE_WORDS - 1; i++) data[f_idx][i] <= fill_buf[i];
        data[f_idx][LINE_WORDS-1] <= mem_resp_data;
      end
    end
endmodule

// File: tb/tb_inst_cache.sv
// tb_inst_cache: scenario tasks plus randomized traffic checked against an array-based cache model
module tb_inst_cache;
  logic clk = 0, rst = 1, rdy = 1, flush = 0, mem_resp_valid = 0;
  logic [31:0] pc_in = 32'h1004, mem_resp_data = 0;
  logic inst_valid, mem_req_valid;
  logic [31:0] inst_out, mem_req_addr;
  int errors = 0, checks = 0;
  logic [31:0] salt;
  bit mv [32];
  logic [22:0] mt [32];
  logic [31:0] req_q [$];
  bit fill_vld_seen;

  inst_cache #(.INDEX_BITS(5)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .pc_in(pc_in), .inst_valid(inst_valid), .inst_out(inst_out),
    .flush(flush), .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ({a[31:2], 2'b00} * 32'h9E37_79B1) ^ salt;
  endfunction
  function automatic bit model_hit(input logic [31:0] a);
    return mv[a[8:4]] && mt[a[8:4]] == a[31:9];
  endfunction
  function automatic void model_fill(input logic [31:0] a);
    mv[a[8:4]] = 1;
    mt[a[8:4]] = a[31:9];
  endfunction
  function automatic void model_flush();
    for (int i = 0; i < 32; i++) mv[i] = 0;
  endfunction
  function automatic bit seq_ok(input logic [31:0] base);
    if (req_q.size() != 4) return 0;
    for (int i = 0; i < 4; i++) if (req_q[i] !== base + 32'(4 * i)) return 0;
    return 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // memory responder: answers outstanding requests with random gaps, optional pc redirect
  task automatic serve(input int gap, input int redir_at, input logic [31:0] redir_pc, output bit ok);
    int got = 0;
    req_q.delete();
    fill_vld_seen = 0;
    for (int c = 0; c < 300 && got < 4; c++) begin
      #1;
      if (inst_valid) fill_vld_seen = 1;
      if (mem_req_valid && $urandom_range(gap, 0) == 0) begin
        req_q.push_back(mem_req_addr);
        mem_resp_valid = 1;
        mem_resp_data = mem_word(mem_req_addr);
        got++;
        if (got == redir_at) pc_in = redir_pc;
      end
      tick();
      mem_resp_valid = 0;
    end
    ok = got == 4;
  endtask

  task automatic test_reset();
    rst = 1;
    rdy = 1;
    pc_in = 32'h1004;
    tick();
    tick();
    #1;
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", mem_req_valid); end
    checks++; if (mem_req_addr !== 32'h0) begin errors++; $display("FAIL reset_req_addr: got %h expected 0", mem_req_addr); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %b expected 0", inst_valid); end
    rst = 0;
    model_flush();
  endtask

  task automatic test_cold_miss();
    bit ok;
    pc_in = 32'h1004;
    #1;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL cold_miss_valid: got %b expected 0", inst_valid); end
    tick();
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h1000) begin errors++; $display("FAIL cold_first_req: got %b/%h expected 1/00001000", mem_req_valid, mem_req_addr); end
    serve(1, 0, 0, ok);
    checks++; if (!ok || !seq_ok(32'h1000)) begin errors++; $display("FAIL cold_req_seq: got %0d requests ok=%b expected 1000..100c", req_q.size(), ok); end
    checks++; if (fill_vld_seen) begin errors++; $display("FAIL cold_valid_in_fill: got 1 expected 0"); end
    model_fill(32'h1000);
    #1;
    checks++; if (inst_valid !== 1'b1 || inst_out !== mem_word(32'h1004)) begin errors++; $display("FAIL cold_hit_after: got %b/%h expected 1/%h", inst_valid, inst_out, mem_word(32'h1004)); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL cold_req_drop: got %b expected 0", mem_req_valid); end
  endtask

  task automatic test_hit_sweep();
    logic [31:0] pcs [3] = '{32'h1000, 32'h1008, 32'h100C};
    for (int i = 0; i < 3; i++) begin
      pc_in = pcs[i];
      mem_resp_valid = 1;
      mem_resp_data = $urandom;
      #1;
      checks++; if (inst_valid !== 1'b1 || inst_out !== mem_word(pcs[i])) begin errors++; $display("FAIL hit_sweep %h: got %b/%h expected 1/%h", pcs[i], inst_valid, inst_out, mem_word(pcs[i])); end
      tick();
      checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL hit_sweep_req %h: got %b expected 0", pcs[i], mem_req_valid); end
    end
    mem_resp_valid = 0;
  endtask

  task automatic test_flush_idle();
    bit ok;
    pc_in = 32'h1000;
    flush = 1;
    #1;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL flush_forces_miss: got %b expected 0", inst_valid); end
    tick();
    tick();
    flush = 0;
    model_flush();
    #1;
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL flush_no_fill: got %b expected 0", mem_req_valid); end
    checks++; if (inst_valid !== model_hit(32'h1000)) begin errors++; $display("FAIL flush_cleared: got %b expected 0", inst_valid); end
    tick();
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h1000) begin errors++; $display("FAIL flush_refill_req: got %b/%h expected 1/00001000", mem_req_valid, mem_req_addr); end
    serve(0, 0, 0, ok);
    checks++; if (!ok || !seq_ok(32'h1000)) begin errors++; $display("FAIL flush_refill_seq: got %0d requests expected 4", req_q.size()); end
    model_fill(32'h1000);
  endtask

  task automatic test_alias();
    bit ok;
    pc_in = 32'h1200;
    #1;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL alias_miss: got %b expected 0", inst_valid); end
    tick();
    checks++; if (mem_req_addr !== 32'h1200) begin errors++; $display("FAIL alias_req: got %h expected 00001200", mem_req_addr); end
    serve(2, 0, 0, ok);
    checks++; if (!ok || !seq_ok(32'h1200)) begin errors++; $display("FAIL alias_seq: got %0d requests expected 1200..120c", req_q.size()); end
    model_fill(32'h1200);
    pc_in = 32'h1204;
    #1;
    checks++; if (inst_valid !== 1'b1 || inst_out !== mem_word(32'h1204)) begin errors++; $display("FAIL alias_hit: got %b/%h expected 1/%h", inst_valid, inst_out, mem_word(32'h1204)); end
    pc_in = 32'h1000;
    #1;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL alias_evicted: got %b expected 0", inst_valid); end
    pc_in = 32'h1200;
  endtask

  task automatic test_redirect();
    bit ok;
    pc_in = 32'h1000;
    tick();
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h1000) begin errors++; $display("FAIL redir_req: got %b/%h expected 1/00001000", mem_req_valid, mem_req_addr); end
    serve(1, 2, 32'h2040, ok);
    checks++; if (!ok || !seq_ok(32'h1000)) begin errors++; $display("FAIL redir_seq: got %0d requests expected 1000..100c", req_q.size()); end
    model_fill(32'h1000);
    #1;
    checks++; if (mem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL redir_idle: got req %b valid %b expected 0/0", mem_req_valid, inst_valid); end
    tick();
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h2040) begin errors++; $display("FAIL redir_new_req: got %b/%h expected 1/00002040", mem_req_valid, mem_req_addr); end
    serve(0, 0, 0, ok);
    checks++; if (!ok || !seq_ok(32'h2040)) begin errors++; $display("FAIL redir_new_seq: got %0d requests expected 4", req_q.size()); end
    model_fill(32'h2040);
    pc_in = 32'h1008;
    #1;
    checks++; if (inst_valid !== 1'b1 || inst_out !== mem_word(32'h1008)) begin errors++; $display("FAIL redir_old_line: got %b/%h expected 1/%h", inst_valid, inst_out, mem_word(32'h1008)); end
  endtask

  task automatic test_stall_reset();
    bit ok;
    pc_in = 32'h3000;
    tick();
    checks++; if (mem_req_addr !== 32'h3000) begin errors++; $display("FAIL stall_req: got %h expected 00003000", mem_req_addr); end
    for (int i = 0; i < 2; i++) begin
      mem_resp_valid = 1;
      mem_resp_data = mem_word(mem_req_addr);
      tick();
      mem_resp_valid = 0;
    end
    rdy = 0;
    for (int i = 0; i < 3; i++) begin
      mem_resp_valid = 1;
      mem_resp_data = 32'hDEAD_BEEF;
      tick();
      checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h3008) begin errors++; $display("FAIL stall_hold %0d: got %b/%h expected 1/00003008", i, mem_req_valid, mem_req_addr); end
    end
    rdy = 1;
    mem_resp_valid = 0;
    for (int i = 0; i < 2; i++) begin
      mem_resp_valid = 1;
      mem_resp_data = mem_word(mem_req_addr);
      tick();
      mem_resp_valid = 0;
    end
    model_fill(32'h3000);
    pc_in = 32'h3008;
    #1;
    checks++; if (inst_valid !== 1'b1 || inst_out !== mem_word(32'h3008)) begin errors++; $display("FAIL stall_data: got %b/%h expected 1/%h", inst_valid, inst_out, mem_word(32'h3008)); end
    pc_in = 32'h2040;
    #1;
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL pre_rst_hit: got %b expected 1", inst_valid); end
    pc_in = 32'h5010;
    tick();
    mem_resp_valid = 1;
    mem_resp_data = mem_word(mem_req_addr);
    tick();
    mem_resp_valid = 0;
    rst = 1;
    rdy = 0;
    flush = 1;
    tick();
    rst = 0;
    rdy = 1;
    flush = 0;
    model_flush();
    pc_in = 32'h2040;
    #1;
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_fill_abort: got %b expected 0", mem_req_valid); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_clears_line: got %b expected 0", inst_valid); end
    pc_in = 32'h5010;
    tick();
    checks++; if (mem_req_addr !== 32'h5010) begin errors++; $display("FAIL rst_refill_req: got %h expected 00005010", mem_req_addr); end
    serve(1, 0, 0, ok);
    checks++; if (!ok || !seq_ok(32'h5010)) begin errors++; $display("FAIL rst_refill_seq: got %0d requests expected 4", req_q.size()); end
    model_fill(32'h5010);
  endtask

  task automatic test_flush_in_fill();
    bit ok;
    pc_in = 32'h6020;
    tick();
    flush = 1;
    tick();
    flush = 0;
    model_flush();
    serve(1, 0, 0, ok);
    checks++; if (!ok || !seq_ok(32'h6020)) begin errors++; $display("FAIL flush_fill_seq: got %0d requests expected 4", req_q.size()); end
    model_fill(32'h6020);
    pc_in = 32'h602C;
    #1;
    checks++; if (inst_valid !== 1'b1 || inst_out !== mem_word(32'h602C)) begin errors++; $display("FAIL flush_fill_line: got %b/%h expected 1/%h", inst_valid, inst_out, mem_word(32'h602C)); end
    pc_in = 32'h5010;
    #1;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL flush_fill_others: got %b expected 0", inst_valid); end
    pc_in = 32'h6020;
  endtask

  task automatic test_random();
    logic [31:0] a, base;
    bit h, ok;
    for (int n = 0; n < 60; n++) begin
      a = 32'h4000_0000 | (32'($urandom_range(2, 0)) << 9) | (32'($urandom_range(7, 0)) << 4) | (32'($urandom_range(3, 0)) << 2);
      base = a & ~32'hF;
      if ($urandom_range(9, 0) == 0) begin
        pc_in = a;
        flush = 1;
        #1;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rand_flush %h: got %b expected 0", a, inst_valid); end
        tick();
        flush = 0;
        model_flush();
      end
      pc_in = a;
      #1;
      h = model_hit(a);
      checks++; if (inst_valid !== h) begin errors++; $display("FAIL rand_hit %h: got %b expected %b", a, inst_valid, h); end
      if (h) begin
        checks++; if (inst_out !== mem_word(a)) begin errors++; $display("FAIL rand_data %h: got %h expected %h", a, inst_out, mem_word(a)); end
      end
      tick();
      if (!h) begin
        checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== base) begin errors++; $display("FAIL rand_req %h: got %b/%h expected 1/%h", a, mem_req_valid, mem_req_addr, base); end
        serve(2, 0, 0, ok);
        checks++; if (!ok || !seq_ok(base) || fill_vld_seen) begin errors++; $display("FAIL rand_fill %h: got %0d requests ok=%b expected 4", a, req_q.size(), ok); end
        model_fill(a);
      end else begin
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rand_no_req %h: got %b expected 0", a, mem_req_valid); end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    salt = $urandom;
    test_reset();
    test_cold_miss();
    test_hit_sweep();
    test_flush_idle();
    test_alias();
    test_redirect();
    test_stall_reset();
    test_flush_in_fill();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
